// File: rtl/arb_pkg.sv
// Shared state type and index/one-hot helpers for the round-robin burst arbiter.
// Used by rr_burst_arbiter and rr_prio_pick.
package arb_pkg;

  // Upper bound on requester count supported by the one-hot helpers.
  localparam int unsigned ARB_MAX_CORES = 64;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Width of a binary core index; a single core still gets a 1-bit index.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [ARB_MAX_CORES-1:0] arb_onehot(input int unsigned idx);
    logic [ARB_MAX_CORES-1:0] oh;
    oh = ARB_MAX_CORES'(1) << idx;
    return oh;
  endfunction

  function automatic int unsigned arb_idx(input logic [ARB_MAX_CORES-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < ARB_MAX_CORES; i++) begin
      if (oh[i]) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr,
// wrapping to 0, found by searching the request vector rotated down by ptr.
module rr_prio_pick #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     win_idx,
  output logic                 win_valid
);

  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0]   rot;
  int unsigned            off;
  int unsigned            sum;
  logic                   found;

  always_comb begin
    dbl   = {req, req};
    rot   = NUM_CORES'(dbl >> ptr);
    off   = 0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!found && rot[k]) begin
        off   = unsigned'(k);
        found = 1'b1;
      end
    end
    // Explicit wrap so non-power-of-two core counts index correctly.
    sum = 32'(ptr) + off;
    if (sum >= unsigned'(NUM_CORES)) sum = sum - unsigned'(NUM_CORES);
    win_idx   = IDX_W'(sum);
    win_valid = |req;
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Work-conserving round-robin arbiter with burst locking and registered grants.
// Optional burst-length limit is enabled by defining ARB_BURST_LIMIT_EN.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  parameter  int MAX_BURST = 8,
  localparam int IDX_W     = arb_idx_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] req,
  input  logic [NUM_CORES-1:0] lock,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic                 grant_start
);

  if (NUM_CORES < 1 || MAX_BURST < 1) begin : g_bad_param
    $error("rr_burst_arbiter: NUM_CORES and MAX_BURST must both be >= 1");
  end

  arb_state_t           state_q;
  logic [NUM_CORES-1:0] grant_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 valid_q;
  logic                 start_q;

  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [NUM_CORES-1:0] win_oh;
  logic [IDX_W-1:0]     ptr_d;
  logic                 keep;
  logic                 limit_hit;

  rr_prio_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    win_oh = NUM_CORES'(arb_onehot(32'(win_idx)));
    ptr_d  = (win_idx == IDX_W'(NUM_CORES - 1)) ? '0 : win_idx + IDX_W'(1);
    // grant_q is zero in IDLE, so keep can only assert for a current owner.
    keep   = (|(grant_q & req & lock)) & ~limit_hit;
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int              BEAT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST - 1);

  logic [BEAT_W-1:0] beat_q;

  assign limit_hit = (beat_q == BEAT_MAX) && (|(req & ~grant_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else if (keep) begin
      if (beat_q != BEAT_MAX) beat_q <= beat_q + BEAT_W'(1);
    end else begin
      beat_q <= '0;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= OWN;
            grant_q <= win_oh;
            idx_q   <= win_idx;
            ptr_q   <= ptr_d;
            valid_q <= 1'b1;
            start_q <= 1'b1;
          end
        end
        OWN: begin
          if (keep) begin
            start_q <= 1'b0;
          end else if (win_valid) begin
            // Handoff in the same edge; the old owner already sits behind ptr.
            grant_q <= win_oh;
            idx_q   <= win_idx;
            ptr_q   <= ptr_d;
            valid_q <= 1'b1;
            start_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign grant_start = start_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal grant sequences.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  lock  = '0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          grant_start;

  int vectors     = 0;
  int miscompares = 0;

  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_beats = 0;
  bit           m_start = 1'b0;
  bit           m_keep;
  int           m_w;
  logic [N-1:0] m_bit;
`ifdef ARB_BURST_LIMIT_EN
  bit           m_others;
`endif

  rr_burst_arbiter #(.NUM_CORES(N), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_start (grant_start)
  );

  always #5 clk = ~clk;

  // Model: owner id, rotating pointer, cycles held in the current burst.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_start = 1'b0;
    end else begin
      m_keep = 1'b0;
      if (m_owner >= 0) begin
        m_bit  = N'(1) << m_owner;
        m_keep = (req & lock & m_bit) != '0;
`ifdef ARB_BURST_LIMIT_EN
        m_others = (req & ~m_bit) != '0;
        if (m_beats >= MB && m_others) m_keep = 1'b0;
`endif
      end
      if (m_keep) begin
        m_beats = m_beats + 1;
        m_start = 1'b0;
      end else begin
        m_w = -1;
        for (int k = 0; k < N; k++) begin
          if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        end
        if (m_w >= 0) begin
          m_owner = m_w;
          m_ptr   = (m_w + 1) % N;
          m_beats = 1;
          m_start = 1'b1;
        end else begin
          m_owner = -1;
          m_start = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    vectors++;
    if (grant !== eg) begin
      miscompares++;
      $display("FAIL model_grant t=%0t: got %b, required %b", $time, grant, eg);
    end
    if (grant_valid !== (m_owner >= 0)) begin
      miscompares++;
      $display("FAIL model_valid t=%0t: got %b, required %b", $time, grant_valid, (m_owner >= 0));
    end
    if (grant_start !== m_start) begin
      miscompares++;
      $display("FAIL model_start t=%0t: got %b, required %b", $time, grant_start, m_start);
    end
    if (m_owner >= 0 && grant_idx !== IW'(m_owner)) begin
      miscompares++;
      $display("FAIL model_idx t=%0t: got %0d, required %0d", $time, grant_idx, m_owner);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [N-1:0] eg, input logic es);
    vectors++;
    if (grant !== eg || grant_start !== es) begin
      miscompares++;
      $display("FAIL %s t=%0t: grant=%b start=%b, required grant=%b start=%b",
               name, $time, grant, grant_start, eg, es);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] tab_req  [12] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0110, 4'b0110,
                                  4'b1001, 4'b0000, 4'b0010, 4'b1100, 4'b1100, 4'b1100};
  logic [N-1:0] tab_lock [12] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0110, 4'b0110,
                                  4'b1001, 4'b0000, 4'b0010, 4'b1100, 4'b1100, 4'b1100};

  initial begin
    int           gc;
    int           sc;
    logic [N-1:0] eg;
    logic         es;

    // Alternating non-locked requesters held from reset.
    #1 rst_n = 1'b0;
    req  = 4'b0101;
    lock = 4'b0000;
    #1;
    lit("reset_grant", 4'b0000, 1'b0);
    chk("reset_valid", int'(grant_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); lit("alt_1", 4'b0001, 1'b1);
    chk("alt_1_idx", int'(grant_idx), 0);
    tick(); lit("alt_2", 4'b0100, 1'b1);
    chk("alt_2_idx", int'(grant_idx), 2);
    tick(); lit("alt_3", 4'b0001, 1'b1);
    tick(); lit("alt_4", 4'b0100, 1'b1);
    req = 4'b0000;
    tick(); lit("alt_idle", 4'b0000, 1'b0);

    // Pointer wrap from core 3 back to core 0.
    do_reset();
    req = 4'b1000;
    tick(); lit("wrap_1", 4'b1000, 1'b1);
    chk("wrap_1_idx", int'(grant_idx), 3);
    req = 4'b1001;
    tick(); lit("wrap_2", 4'b0001, 1'b1);
    tick(); lit("wrap_3", 4'b1000, 1'b1);
    req = 4'b0000;
    tick(); lit("wrap_idle", 4'b0000, 1'b0);

    // Core 2 locked burst of 10 request cycles while core 0 waits.
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    tick(); lit("burst_1", 4'b0100, 1'b1);
    req = 4'b0101;
    for (int t = 2; t <= 10; t++) begin
      tick();
`ifdef ARB_BURST_LIMIT_EN
      eg = (t == 5 || t == 10) ? 4'b0001 : 4'b0100;
      es = (t == 5 || t == 6 || t == 10);
`else
      eg = 4'b0100;
      es = 1'b0;
`endif
      lit($sformatf("burst_%0d", t), eg, es);
    end
    req  = 4'b0001;
    lock = 4'b0000;
    tick(); lit("burst_after", 4'b0001, 1'b1);
    req = 4'b0000;
    tick(); lit("burst_idle", 4'b0000, 1'b0);

    // Sole locked requester never gets cut.
    req  = 4'b0010;
    lock = 4'b0010;
    gc = 0;
    sc = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (grant == 4'b0010) gc++;
      if (grant_start) sc++;
    end
    chk("solo_grant_cycles", gc, 20);
    chk("solo_start_pulses", sc, 1);
    req  = 4'b0000;
    lock = 4'b0000;
    tick(); lit("solo_idle", 4'b0000, 1'b0);

    // Reset in the middle of a core 3 burst, restart from ptr 0.
    req  = 4'b1000;
    lock = 4'b1000;
    tick(); lit("mid_1", 4'b1000, 1'b1);
    tick(); lit("mid_2", 4'b1000, 1'b0);
    tick(); lit("mid_3", 4'b1000, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    lit("mid_reset", 4'b0000, 1'b0);
    chk("mid_reset_valid", int'(grant_valid), 0);
    req  = 4'b1010;
    lock = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); lit("mid_after", 4'b0010, 1'b1);
    chk("mid_after_idx", int'(grant_idx), 1);

    // Mixed patterns, checked by the model only.
    for (int i = 0; i < 12; i++) begin
      req  = tab_req[i];
      lock = tab_lock[i];
      tick();
    end
    req  = 4'b0000;
    lock = 4'b0000;
    tick();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
